// File: rtl/debounce_multi.sv
// N-channel debouncer driven by one shared sample tick.
// Each channel provides a debounced level, rise/fall pulses and long-press/auto-repeat hold pulses.
module debounce_multi #(
    parameter int            CH           = 8,
    parameter int            TICK_DIV     = 1000000,
    parameter int            STABLE_N     = 3,
    parameter int            LONG_TICKS   = 100,
    parameter int            REPEAT_TICKS = 20,
    parameter logic [CH-1:0] ACTIVE_LOW   = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] hold,
    output logic          tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_N + 1);
    localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE   = TW'(TICK_DIV - 2);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_N - 1);
    localparam logic [HW-1:0] HOLD_PRE   = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0] HOLD_FIRST = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_WRAP  = HW'(LONG_TICKS + REPEAT_TICKS - 1);

    logic [CH-1:0] sync_a;
    logic [CH-1:0] sync_b;
    logic [CH-1:0] s;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] stab_cnt [CH];
    logic [HW-1:0] hold_cnt [CH];
    logic [CH-1:0] accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b ^ ACTIVE_LOW;

    // tick is registered one count early so it is high exactly while tick_cnt == TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            tick     <= (tick_cnt == TICK_PRE);
        end
    end

    // NOTE: default assigned before the loop so no path leaves accept unassigned (no latch).
    always_comb begin
        accept = '0;
        for (int i = 0; i < CH; i++) begin
            accept[i] = tick && (s[i] != level[i]) && (stab_cnt[i] == STAB_LAST);
        end
    end

    // NOTE: the per-channel counters are plain registers, not RAM, so they take the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            hold  <= '0;
            for (int i = 0; i < CH; i++) begin
                stab_cnt[i] <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
            hold <= '0;
            for (int i = 0; i < CH; i++) begin
                if (accept[i]) begin
                    level[i] <= s[i];
                end

                if (tick) begin
                    if (accept[i] || (s[i] == level[i])) begin
                        stab_cnt[i] <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + SW'(1);
                    end
                end

                // Hold counter restarts on the accepting edge and whenever the level is low.
                if (accept[i] || !level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (tick) begin
                    if ((REPEAT_TICKS > 0) && (hold_cnt[i] == HOLD_WRAP)) begin
                        hold[i]     <= 1'b1;
                        hold_cnt[i] <= HOLD_FIRST;
                    end else if (hold_cnt[i] == HOLD_PRE) begin
                        hold[i]     <= 1'b1;
                        hold_cnt[i] <= HOLD_FIRST;
                    end else if ((REPEAT_TICKS > 0) || (hold_cnt[i] != HOLD_FIRST)) begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    end
                end
            end
        end
    end

endmodule
